divisor_programable: RTL and testbench

DIVISOR_PROGRAMABLE -- requirements
Module: divisor_programable

---
 rtl/divisor_programable_if.sv | 25 ++
 rtl/divisor_programable.sv | 85 ++++++++
 tb/tb_divisor_programable.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/divisor_programable_if.sv
// Control and output bundle of the programmable clock divider.
// Strobe semantics: div_load and start act only on the rising edge that samples them high; no ready/ack exists.
interface divisor_programable_if #(
    parameter int WIDTH = 26
);
    logic             enable;
    logic             modo;
    logic             start;
    logic             div_load;
    logic [WIDTH-1:0] div_value;
    logic             salida;
    logic             pulso;
    logic             busy;
    logic             state_dbg;

    modport master (
        output enable, modo, start, div_load, div_value,
        input  salida, pulso, busy, state_dbg
    );

    modport slave (
        input  enable, modo, start, div_load, div_value,
        output salida, pulso, busy, state_dbg
    );
endinterface

// File: rtl/divisor_programable.sv
// Programmable divider: square wave on salida with half-period div_reg+1 cycles,
// one-cycle pulso at each terminal count, continuous or one-shot operation.
module divisor_programable #(
    parameter int WIDTH     = 26,
    parameter int DIV_RESET = 10000000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    divisor_programable_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] div_reg_q, div_reg_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             salida_q, salida_d;
    logic             pulso_q, pulso_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            div_reg_q <= WIDTH'(DIV_RESET);
            count_q   <= '0;
            salida_q  <= 1'b0;
            pulso_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_reg_q <= div_reg_d;
            count_q   <= count_d;
            salida_q  <= salida_d;
            pulso_q   <= pulso_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_reg_d = div_reg_q;
        count_d   = count_q;
        salida_d  = salida_q;
        pulso_d   = 1'b0;

        // A load outranks everything, including a coincident terminal count or entry into RUN.
        if (bus.div_load) begin
            div_reg_d = bus.div_value;
            count_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    count_d = '0;
                    if (bus.enable && (!bus.modo || bus.start)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (bus.enable) begin
                        if (count_q == div_reg_q) begin
                            count_d  = '0;
                            salida_d = ~salida_q;
                            pulso_d  = 1'b1;
                            if (bus.modo) begin
                                state_d = IDLE;
                            end
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign bus.salida    = salida_q;
    assign bus.pulso     = pulso_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_divisor_programable.sv
// Bench for divisor_programable (WIDTH=4, DIV_RESET=3): directed table, corner sequences,
// and randomized traffic compared against a pulse-countdown reference model.
module tb_divisor_programable;

    localparam int W = 4;

    logic clock;
    logic reset_n;

    divisor_programable_if #(.WIDTH(W)) bus ();

    divisor_programable #(.WIDTH(W), .DIV_RESET(3)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard counters ----------------
    int n_vec;
    int n_err;

    // ---------------- reference model ----------------
    // Divider value, edges left until the next terminal, running flag and outputs.
    int m_n;
    int m_left;
    bit m_run;
    bit m_sal;
    bit m_pul;

    task automatic model_reset();
        m_n    = 3;
        m_left = 4;
        m_run  = 0;
        m_sal  = 0;
        m_pul  = 0;
    endtask

    task automatic model_edge(input bit en, input bit mo, input bit st,
                              input bit ld, input int val);
        m_pul = 0;
        if (ld) begin
            m_n    = val;
            m_left = m_n + 1;
        end else if (!m_run) begin
            if (en && (!mo || st)) begin
                m_run  = 1;
                m_left = m_n + 1;
            end
        end else if (en) begin
            if (m_left == 1) begin
                m_pul  = 1;
                m_sal  = !m_sal;
                m_left = m_n + 1;
                if (mo) m_run = 0;
            end else begin
                m_left = m_left - 1;
            end
        end
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drive inputs, take one rising edge, advance the model, sample 1ns later.
    task automatic step(input bit en, input bit mo, input bit st, input bit ld,
                        input int val, input string tag);
        bus.enable    = en;
        bus.modo      = mo;
        bus.start     = st;
        bus.div_load  = ld;
        bus.div_value = W'(val);
        @(posedge clock);
        model_edge(en, mo, st, ld, val);
        #1;
        check({tag, "_salida"}, bus.salida, m_sal);
        check({tag, "_pulso"},  bus.pulso,  m_pul);
        check({tag, "_busy"},   bus.busy,   m_run);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit en;
        bit mo;
        bit st;
        bit ld;
        int val;
        bit exp_sal;
        bit exp_pul;
        bit exp_busy;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int  pulses;
        bit  sal_before;

        n_vec = 0;
        n_err = 0;
        bus.enable    = 0;
        bus.modo      = 0;
        bus.start     = 0;
        bus.div_load  = 0;
        bus.div_value = '0;
        reset_n       = 1'b0;
        model_reset();

        // Continuous run from reset with div 3: pulse at edge 5, then every 4 edges.
        tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 1};
        tbl[1] = '{1, 0, 0, 0, 0, 0, 0, 1};
        tbl[2] = '{1, 0, 0, 0, 0, 0, 0, 1};
        tbl[3] = '{1, 0, 0, 0, 0, 0, 0, 1};
        tbl[4] = '{1, 0, 0, 0, 0, 1, 1, 1};
        tbl[5] = '{1, 0, 0, 0, 0, 1, 0, 1};
        tbl[6] = '{1, 0, 0, 0, 0, 1, 0, 1};
        tbl[7] = '{1, 0, 0, 0, 0, 1, 0, 1};
        tbl[8] = '{1, 0, 0, 0, 0, 0, 1, 1};
        tbl[9] = '{1, 0, 0, 0, 0, 0, 0, 1};

        #12;
        check("reset_salida", bus.salida, 1'b0);
        check("reset_pulso",  bus.pulso,  1'b0);
        check("reset_busy",   bus.busy,   1'b0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].en, tbl[i].mo, tbl[i].st, tbl[i].ld, tbl[i].val, "tbl");
            check($sformatf("tbl%0d_salida", i), bus.salida, tbl[i].exp_sal);
            check($sformatf("tbl%0d_pulso", i),  bus.pulso,  tbl[i].exp_pul);
            check($sformatf("tbl%0d_busy", i),   bus.busy,   tbl[i].exp_busy);
        end

        // Load div 0 while running: count cleared, then toggle and pulse every cycle.
        step(1, 0, 0, 1, 0, "ld0");
        check("ld0_no_pulse", bus.pulso, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sal_before = bus.salida;
            step(1, 0, 0, 0, 0, "div0");
            check("div0_pulse_held", bus.pulso, 1'b1);
            check("div0_toggle", bus.salida, !sal_before);
        end

        // One-shot with div 2: single pulse after edge 4, busy falls, start while busy ignored.
        do_reset();
        step(0, 1, 0, 1, 2, "os_ld");
        step(1, 1, 1, 0, 0, "os_start");
        check("os_busy_entry", bus.busy, 1'b1);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, 1, (i == 0), 0, 0, "os_run");
            if (bus.pulso) pulses++;
        end
        check("os_pulse_edge4", bus.pulso, 1'b1);
        check("os_busy_after", bus.busy, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0, 0, "os_idle");
            if (bus.pulso) pulses++;
        end
        check_int("os_pulse_count", pulses, 1);
        step(0, 1, 1, 0, 0, "os_start_disabled");
        step(1, 1, 0, 0, 0, "os_not_remembered");
        check("os_start_forgotten", bus.busy, 1'b0);

        // Pause for 3 cycles at count 1, then terminal 3 edges after re-enable.
        do_reset();
        step(1, 0, 0, 0, 0, "pz_entry");
        step(1, 0, 0, 0, 0, "pz_cnt1");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, "pz_hold");
            check("pz_hold_pulso", bus.pulso, 1'b0);
            check("pz_hold_busy", bus.busy, 1'b1);
        end
        step(1, 0, 0, 0, 0, "pz_re1");
        check("pz_re1_pulso", bus.pulso, 1'b0);
        step(1, 0, 0, 0, 0, "pz_re2");
        check("pz_re2_pulso", bus.pulso, 1'b0);
        step(1, 0, 0, 0, 0, "pz_re3");
        check("pz_re3_pulso", bus.pulso, 1'b1);

        // Load landing on the terminal edge suppresses toggle and pulse.
        step(1, 0, 0, 0, 0, "tl_c1");
        step(1, 0, 0, 0, 0, "tl_c2");
        step(1, 0, 0, 0, 0, "tl_c3");
        sal_before = bus.salida;
        step(1, 0, 0, 1, 5, "tl_load");
        check("tl_no_pulse", bus.pulso, 1'b0);
        check("tl_no_toggle", bus.salida, sal_before);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 0, 0, "tl_new_div");
            if (bus.pulso) pulses++;
        end
        check("tl_new_div_terminal", bus.pulso, 1'b1);
        check_int("tl_new_div_pulses", pulses, 1);

        // Asynchronous reset between edges while salida is high.
        while (!m_sal) step(1, 0, 0, 0, 0, "ar_run");
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("ar_salida", bus.salida, 1'b0);
        check("ar_pulso",  bus.pulso,  1'b0);
        check("ar_busy",   bus.busy,   1'b0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 13; i++) begin
            step(1, 0, 0, 0, 0, "ar_restart");
            if (bus.pulso) pulses++;
        end
        check_int("ar_period8_pulses", pulses, 3);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 24) == 0),
                 $urandom_range(0, 5),
                 "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
